ct_biu_lpmd_gate_ctrl: RTL and testbench
========================================

// Module: ct_biu_lpmd_gate_ctrl
// PURPOSE
//  Parametrised clock-enable and low-power-mode controller for BIU channels.
//  - Per channel: clock-enable hold-off, i.e. the enable is extended a programmable number of cycles.
//  - Derives biu_yy_xx_no_op from an idle counter.
//  - Runs a req/ack drain handshake with CP0 for low-power entry.
//  - Outputs drive the local_en pins of the channel gated_clk_cell instances.
// PARAMETERS
//  NUM_CH   12      number of gated channels
//  HOLD_W   4       width of per-channel hold-off counter
//  IDLE_W   6       width of idle counter / threshold
//  AON_MASK 12'h800 channels kept alive in LP (snoop AC); excluded from drain check
// PORTS
//  forever_coreclk     in  1       ungated core clock; all flops on rising edge
//  cpurst              in  1       synchronous reset, active-high
//  cp0_biu_icg_en      in  1       1 = gating allowed; 0 = all ch_gate_en forced 1
//  pad_yy_icg_scan_en  in  1       scan: all ch_gate_en forced 1, overrides LP state
//  cp0_biu_hold_cnt    in  HOLD_W  hold-off cycles loaded on each local enable
//  cp0_biu_idle_thresh in  IDLE_W  consecutive idle cycles required before no_op
//  cp0_biu_lpmd_req    in  1       level request to enter low-power mode
//  ch_clk_en           in  NUM_CH  raw per-channel local clock enables
//  ch_busy             in  NUM_CH  per-channel outstanding-transaction flags
//  ch_gate_en          out NUM_CH  to gated_clk_cell local_en (combinational)
//  biu_yy_xx_no_op     out 1       registered: BIU idle >= threshold
//  biu_cp0_lpmd_ack    out 1       registered: LP entered
//  biu_lpmd_block      out 1       registered: channels must not accept new requests
// BEHAVIOUR
//  Reset (cpurst=1 at edge):
//  - hold_cnt[i]=0, idle_cnt=0, state=RUN.
//  - no_op=0, ack=0, block=0.
//  Hold-off, per channel i:
//  - ch_clk_en[i]=1: hold_cnt[i] <= cp0_biu_hold_cnt.
//  - Else if hold_cnt[i]!=0: hold_cnt[i] <= hold_cnt[i]-1. No wrap below 0.
//  - hold_cnt=0 when ch_clk_en falls: enable drops the same cycle (no extension).
//  ch_gate_en[i] =
//    scan | ~icg_en | (state!=LP | AON_MASK[i]) & (ch_clk_en[i] | hold_cnt[i]!=0)
//    | (state==WAKE)
//  Idle counter:
//  - any_busy = |ch_busy.
//  - any_busy=1: idle_cnt <= 0.
//  - Else idle_cnt increments, saturating at cp0_biu_idle_thresh.
//  - no_op <= ~any_busy & (idle_cnt >= thresh). thresh=0: no_op one cycle after busy clears.
//  - Threshold lowered below idle_cnt: the >= compare holds, no_op stays 1.
//  FSM, 2-bit, states RUN/DRAIN/LP/WAKE:
//  - RUN:   lpmd_req -> DRAIN.
//  - DRAIN: block=1.
//      ~lpmd_req -> RUN (abort, no ack).
//      Else if no busy and all hold_cnt zero on non-AON channels -> LP.
//  - LP:    ack=1, block=1; non-AON gate_en=0. ~lpmd_req -> WAKE.
//  - WAKE:  exactly 1 cycle. All gate_en=1, ack=0, block=0, then -> RUN.
//  - block/ack are registered from next-state: ack rises the cycle LP is entered
//    and falls on entry to WAKE.
//  - lpmd_req re-asserted in WAKE: ignored until RUN (next cycle).
//  - Busy rising in LP (AON channel activity only) does not exit LP.
//  - Reset mid-DRAIN/LP: immediate RUN, ack=0, block=0.
//  - cp0_biu_icg_en=0 forces gate_en but does not alter FSM or counters.
// TESTING
//  - Reset, then ch_clk_en[0] pulse 1 cycle, hold_cnt=3 -> gate_en[0] high 4 cycles total,
//    low on the 5th.
//  - busy clears, thresh=5 -> no_op=1 on 6th edge; busy pulse at cycle 3 -> count restarts.
//  - lpmd_req=1 with ch_busy[2]=1 for 10 cycles -> block=1, ack=0.
//    Busy clears -> ack=1 next edge, gate_en[10:0]=0, gate_en[11] follows ch_clk_en[11].
//  - In LP drop lpmd_req -> one WAKE cycle with gate_en=12'hFFF, ack=0, then RUN.
//  - DRAIN abort: req falls before busy clears -> RUN, ack never asserts.
//    scan_en=1 in LP -> all gate_en=1.
//  - cpurst asserted while in LP -> next cycle ack=0, block=0, hold counters 0.

Source files
------------

// File: rtl/ct_biu_lpmd_gate_ctrl.sv
// ---------------------------------------------------------------------------
// ct_biu_lpmd_gate_ctrl
//   Clock-enable and low-power-mode controller for the BIU gated channels.
//   Each channel's local clock enable is stretched by a programmable hold-off.
//   An idle counter produces biu_yy_xx_no_op. A req/ack drain handshake with
//   CP0 moves the block into low-power mode, where only always-on channels
//   keep their clocks.
//
// Ports
//   forever_coreclk     in   ungated core clock; every flop uses its rising edge
//   cpurst              in   synchronous reset, active-high
//   cp0_biu_icg_en      in   1 = gating allowed, 0 = every ch_gate_en forced to 1
//   pad_yy_icg_scan_en  in   scan mode: every ch_gate_en forced to 1
//   cp0_biu_hold_cnt    in   hold-off cycles loaded whenever a local enable is seen
//   cp0_biu_idle_thresh in   idle cycles required before no_op asserts
//   cp0_biu_lpmd_req    in   level request for low-power entry
//   ch_clk_en           in   raw per-channel local clock enables
//   ch_busy             in   per-channel outstanding-transaction flags
//   ch_gate_en          out  gated_clk_cell local_en, combinational
//   biu_yy_xx_no_op     out  registered: BIU idle for at least the threshold
//   biu_cp0_lpmd_ack    out  registered: low-power mode entered
//   biu_lpmd_block      out  registered: channels must not accept new requests
// ---------------------------------------------------------------------------

// Per-channel hold-off counter and gate-enable term.
module ct_biu_lpmd_hold_lane #(
    parameter int HOLD_W = 4,
    parameter bit AON    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic [HOLD_W-1:0] hold_ld,
    input  logic              force_en,
    input  logic              lp_off,
    output logic              gate_en,
    output logic              hold_pend
);
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              hold_nz;

    assign hold_nz = |hold_cnt_q;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (clk_en)
            hold_cnt_d = hold_ld;
        else if (hold_nz)
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) hold_cnt_q <= '0;
        else     hold_cnt_q <= hold_cnt_d;
    end

    // Always-on channels ignore LP suppression and never hold up the drain.
    assign gate_en   = force_en | ((~lp_off | AON) & (clk_en | hold_nz));
    assign hold_pend = hold_nz & ~AON;
endmodule

module ct_biu_lpmd_gate_ctrl #(
    parameter int                NUM_CH   = 12,
    parameter int                HOLD_W   = 4,
    parameter int                IDLE_W   = 6,
    parameter logic [NUM_CH-1:0] AON_MASK = 12'h800
) (
    input  logic              forever_coreclk,
    input  logic              cpurst,
    input  logic              cp0_biu_icg_en,
    input  logic              pad_yy_icg_scan_en,
    input  logic [HOLD_W-1:0] cp0_biu_hold_cnt,
    input  logic [IDLE_W-1:0] cp0_biu_idle_thresh,
    input  logic              cp0_biu_lpmd_req,
    input  logic [NUM_CH-1:0] ch_clk_en,
    input  logic [NUM_CH-1:0] ch_busy,
    output logic [NUM_CH-1:0] ch_gate_en,
    output logic              biu_yy_xx_no_op,
    output logic              biu_cp0_lpmd_ack,
    output logic              biu_lpmd_block
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LP    = 2'd2,
        ST_WAKE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              no_op_q, no_op_d;
    logic              ack_q, ack_d;
    logic              block_q, block_d;

    logic              any_busy;
    logic              force_en;
    logic              lp_off;
    logic [NUM_CH-1:0] hold_pend;
    logic              drain_ok;

    assign any_busy = |ch_busy;
    // WAKE opens every clock for one cycle so channels can resynchronise.
    assign force_en = pad_yy_icg_scan_en | ~cp0_biu_icg_en | (state_q == ST_WAKE);
    assign lp_off   = (state_q == ST_LP);
    assign drain_ok = ~any_busy & ~(|hold_pend);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        ct_biu_lpmd_hold_lane #(
            .HOLD_W (HOLD_W),
            .AON    (AON_MASK[i])
        ) u_lane (
            .clk       (forever_coreclk),
            .rst       (cpurst),
            .clk_en    (ch_clk_en[i]),
            .hold_ld   (cp0_biu_hold_cnt),
            .force_en  (force_en),
            .lp_off    (lp_off),
            .gate_en   (ch_gate_en[i]),
            .hold_pend (hold_pend[i])
        );
    end

    // Idle counter saturates at the threshold; if the threshold is lowered
    // below the current count the count is kept and the >= compare stays true.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (any_busy)
            idle_cnt_d = '0;
        else if (idle_cnt_q < cp0_biu_idle_thresh)
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        no_op_d = ~any_busy & (idle_cnt_q >= cp0_biu_idle_thresh);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (cp0_biu_lpmd_req) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!cp0_biu_lpmd_req) state_d = ST_RUN;
                else if (drain_ok)     state_d = ST_LP;
            end
            ST_LP:    if (!cp0_biu_lpmd_req) state_d = ST_WAKE;
            default:  state_d = ST_RUN;
        endcase
        // Handshake outputs follow the next state so they line up with it.
        ack_d   = (state_d == ST_LP);
        block_d = (state_d == ST_DRAIN) || (state_d == ST_LP);
    end

    always_ff @(posedge forever_coreclk) begin
        if (cpurst) begin
            state_q    <= ST_RUN;
            idle_cnt_q <= '0;
            no_op_q    <= 1'b0;
            ack_q      <= 1'b0;
            block_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            no_op_q    <= no_op_d;
            ack_q      <= ack_d;
            block_q    <= block_d;
        end
    end

    assign biu_yy_xx_no_op  = no_op_q;
    assign biu_cp0_lpmd_ack = ack_q;
    assign biu_lpmd_block   = block_q;
endmodule

// File: tb/tb_ct_biu_lpmd_gate_ctrl.sv
// Directed bench for ct_biu_lpmd_gate_ctrl: a per-cycle vector table followed
// by a hand-written LP entry / WAKE sequence.
module tb_ct_biu_lpmd_gate_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        icg_en;
    logic        scan_en;
    logic [3:0]  hold_cnt;
    logic [5:0]  idle_thresh;
    logic        lpmd_req;
    logic [11:0] clk_en;
    logic [11:0] busy;
    logic [11:0] gate_en;
    logic        no_op;
    logic        ack;
    logic        block;

    ct_biu_lpmd_gate_ctrl dut (
        .forever_coreclk     (clk),
        .cpurst              (rst),
        .cp0_biu_icg_en      (icg_en),
        .pad_yy_icg_scan_en  (scan_en),
        .cp0_biu_hold_cnt    (hold_cnt),
        .cp0_biu_idle_thresh (idle_thresh),
        .cp0_biu_lpmd_req    (lpmd_req),
        .ch_clk_en           (clk_en),
        .ch_busy             (busy),
        .ch_gate_en          (gate_en),
        .biu_yy_xx_no_op     (no_op),
        .biu_cp0_lpmd_ack    (ack),
        .biu_lpmd_block      (block)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, icg, scan, req;
        logic [3:0]  hold;
        logic [5:0]  thr;
        logic [11:0] cen, busy;
        logic [11:0] eg;
        logic        eno, eack, eblk;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Current input values used when a row is appended.
    logic        c_rst = 0, c_icg = 1, c_scan = 0, c_req = 0;
    logic [3:0]  c_hold = 4'd3;
    logic [5:0]  c_thr  = 6'd5;
    logic [11:0] c_cen  = 12'h000, c_busy = 12'h000;

    // Row = inputs applied this cycle; expected gate_en for those inputs and
    // registered outputs as they stand from earlier edges.
    task automatic row(input logic [11:0] eg, input logic eno, input logic eack, input logic eblk);
        vec_t v;
        v.rst = c_rst; v.icg = c_icg; v.scan = c_scan; v.req = c_req;
        v.hold = c_hold; v.thr = c_thr; v.cen = c_cen; v.busy = c_busy;
        v.eg = eg; v.eno = eno; v.eack = eack; v.eblk = eblk;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [11:0] act, input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive_next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- table fill ----------------
        // Reset and hold-off (ch1 busy keeps no_op low)
        c_rst = 1; c_busy = 12'h002;                  row(12'h000, 0, 0, 0);
        c_rst = 0; c_cen = 12'h001;                   row(12'h001, 0, 0, 0);
        c_cen = 12'h000;                              row(12'h001, 0, 0, 0);
                                                      row(12'h001, 0, 0, 0);
                                                      row(12'h001, 0, 0, 0);
                                                      row(12'h000, 0, 0, 0);
        // hold=0: enable drops without extension
        c_hold = 4'd0; c_cen = 12'h004;               row(12'h004, 0, 0, 0);
        c_cen = 12'h000;                              row(12'h000, 0, 0, 0);
        c_icg = 0;                                    row(12'hFFF, 0, 0, 0);
        c_icg = 1; c_scan = 1;                        row(12'hFFF, 0, 0, 0);
        c_scan = 0; c_hold = 4'd3;
        // Idle counter, thresh=5, busy pulse restarts count
        c_busy = 12'h000;                             row(12'h000, 0, 0, 0);
                                                      row(12'h000, 0, 0, 0);
        c_busy = 12'h010;                             row(12'h000, 0, 0, 0);
        c_busy = 12'h000;
        for (int k = 0; k < 6; k++)                   row(12'h000, 0, 0, 0);
        c_thr = 6'd2;                                 row(12'h000, 1, 0, 0);
        // thresh=0: no_op one cycle after busy clears
        c_thr = 6'd0; c_busy = 12'h001;               row(12'h000, 1, 0, 0);
        c_busy = 12'h000;                             row(12'h000, 0, 0, 0);
        c_thr = 6'd5;                                 row(12'h000, 1, 0, 0);
        // LP entry with ch2 busy for 10 cycles
        c_req = 1; c_busy = 12'h004;                  row(12'h000, 0, 0, 0);
        for (int k = 0; k < 9; k++)                   row(12'h000, 0, 0, 1);
        c_busy = 12'h000;                             row(12'h000, 0, 0, 1);
        c_cen = 12'h801;                              row(12'h800, 0, 1, 1);
        c_cen = 12'h000; c_busy = 12'h800;            row(12'h800, 0, 1, 1);
        c_busy = 12'h000;                             row(12'h800, 0, 1, 1);
                                                      row(12'h800, 0, 1, 1);
                                                      row(12'h000, 0, 1, 1);
        c_scan = 1;                                   row(12'hFFF, 0, 1, 1);
        c_scan = 0; c_req = 0;                        row(12'h000, 0, 1, 1);
        c_req = 1;                                    row(12'hFFF, 0, 0, 0);
                                                      row(12'h000, 1, 0, 0);
                                                      row(12'h000, 1, 0, 1);
        c_cen = 12'h001;                              row(12'h000, 1, 1, 1);
        // Reset while in LP with ch0 hold loaded
        c_rst = 1; c_cen = 12'h000;                   row(12'h000, 1, 1, 1);
        c_rst = 0; c_req = 0; c_busy = 12'h002;       row(12'h000, 0, 0, 0);
        // DRAIN abort
        c_req = 1; c_busy = 12'h004;                  row(12'h000, 0, 0, 0);
                                                      row(12'h000, 0, 0, 1);
        c_req = 0;                                    row(12'h000, 0, 0, 1);
        c_busy = 12'h000;                             row(12'h000, 0, 0, 0);
        // DRAIN waits for a non-AON hold counter to expire
        c_req = 1; c_cen = 12'h002;                   row(12'h002, 0, 0, 0);
        c_cen = 12'h000;                              row(12'h002, 0, 0, 1);
                                                      row(12'h002, 0, 0, 1);
                                                      row(12'h002, 0, 0, 1);
                                                      row(12'h000, 0, 0, 1);
        // icg_en=0 in LP forces enables but keeps the FSM in LP
        c_icg = 0;                                    row(12'hFFF, 1, 1, 1);
        c_icg = 1;                                    row(12'h000, 1, 1, 1);

        // ---------------- apply ----------------
        rst = 1; icg_en = 1; scan_en = 0; hold_cnt = 4'd3; idle_thresh = 6'd5;
        lpmd_req = 0; clk_en = '0; busy = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; icg_en = tbl[i].icg; scan_en = tbl[i].scan;
            hold_cnt = tbl[i].hold; idle_thresh = tbl[i].thr; lpmd_req = tbl[i].req;
            clk_en = tbl[i].cen; busy = tbl[i].busy;
            #4;
            chk("gate_en", i, gate_en, tbl[i].eg);
            chk("no_op",   i, {11'd0, no_op}, {11'd0, tbl[i].eno});
            chk("ack",     i, {11'd0, ack},   {11'd0, tbl[i].eack});
            chk("block",   i, {11'd0, block}, {11'd0, tbl[i].eblk});
            drive_next();
        end

        // ---------------- hand-written WAKE sequence ----------------
        rst = 1; lpmd_req = 0; clk_en = '0; busy = '0; icg_en = 1; scan_en = 0;
        drive_next();
        rst = 0;
        #4;
        chk("seq_rst_ack", 0, {11'd0, ack}, 12'd0);
        drive_next();
        lpmd_req = 1;
        begin : wait_ack
            bit got = 0;
            for (int c = 0; c < 8 && !got; c++) begin
                drive_next();
                #4;
                if (ack === 1'b1) got = 1;
            end
            chk("seq_ack_timeout", 1, {11'd0, got}, 12'd1);
        end
        #1;
        chk("seq_lp_gate", 2, gate_en, 12'h000);
        drive_next();
        lpmd_req = 0;
        #4;
        chk("seq_lp_block", 3, {11'd0, block}, 12'd1);
        drive_next();                                  // WAKE now
        #4;
        chk("seq_wake_gate",  4, gate_en, 12'hFFF);
        chk("seq_wake_ack",   5, {11'd0, ack},   12'd0);
        chk("seq_wake_block", 6, {11'd0, block}, 12'd0);
        drive_next();                                  // back to RUN
        #4;
        chk("seq_run_gate",  7, gate_en, 12'h000);
        chk("seq_run_block", 8, {11'd0, block}, 12'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
